memory_stage_unit: RTL

MEMORY_STAGE_UNIT -- requirements
Module: memory_stage_unit

---
 rtl/memory_stage_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/memory_stage_unit.sv
// Memory stage of the pipeline: issues aligned loads/stores over a simple
// req/ack data-memory port, stalls upstream while an access is outstanding,
// and produces the writeback, branch-redirect and HI/LO results.
//
// Handshake: upstream presents an entry with ValidIn and must hold every
// input stable while StallOut=1; the entry is consumed on the rising edge
// where StallOut=0. Toward memory, MemReq and its address/data/MemWe stay
// constant until the edge on which MemAck=1 is sampled, which completes the
// transfer; MemAck is ignored whenever no request is outstanding.
module memory_stage_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidIn,
  input  logic        BranchIn,
  input  logic        ZeroIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic        HiLoWriteIn,
  input  logic [31:0] BranchTargetAddressIn,
  input  logic [63:0] ALUResultIn,
  input  logic [31:0] MemoryWriteDataIn,
  input  logic [4:0]  DestinationRegIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        StallOut,
  output logic        PCSrcOut,
  output logic [31:0] BranchTargetAddressOut,
  output logic        RegWriteOut,
  output logic [31:0] RegisterWriteDataOut,
  output logic [4:0]  DestinationRegOut,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        MisalignedOut,
  output logic        StateDbg
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic        memOp;
  logic        aligned;
  logic        startAccess;
  logic        latRegWrite;
  logic        latMemToReg;
  logic [4:0]  latDest;
  logic [31:0] latAlu;

  assign memOp       = MemReadIn | MemWriteIn;
  assign aligned     = (ALUResultIn[1:0] == 2'b00);
  assign startAccess = (state == IDLE) && ValidIn && memOp && aligned;
  // Gated by Reset so the stall drops the instant reset is asserted.
  assign StallOut    = Reset && (startAccess || ((state == ACCESS) && !MemAck));
  assign StateDbg    = state;

  // FSM, memory request port and the control latched for the pending access
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      MemReq      <= 1'b0;
      MemWe       <= 1'b0;
      MemAddr     <= '0;
      MemWData    <= '0;
      latRegWrite <= 1'b0;
      latMemToReg <= 1'b0;
      latDest     <= '0;
      latAlu      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startAccess) begin
            state       <= ACCESS;
            MemReq      <= 1'b1;
            MemWe       <= MemWriteIn;
            MemAddr     <= ALUResultIn[31:0];
            MemWData    <= MemoryWriteDataIn;
            latRegWrite <= RegWriteIn;
            latMemToReg <= MemToRegIn;
            latDest     <= DestinationRegIn;
            latAlu      <= ALUResultIn[31:0];
          end
        end
        ACCESS: begin
          if (MemAck) begin
            state  <= IDLE;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback, branch redirect, HI/LO and misalignment outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PCSrcOut               <= 1'b0;
      BranchTargetAddressOut <= '0;
      RegWriteOut            <= 1'b0;
      RegisterWriteDataOut   <= '0;
      DestinationRegOut      <= '0;
      HiOut                  <= '0;
      LoOut                  <= '0;
      MisalignedOut          <= 1'b0;
    end else begin
      // Pulse outputs default low; data outputs hold unless reloaded.
      RegWriteOut   <= 1'b0;
      PCSrcOut      <= 1'b0;
      MisalignedOut <= 1'b0;
      if (state == ACCESS) begin
        if (MemAck) begin
          RegWriteOut          <= latRegWrite;
          RegisterWriteDataOut <= latMemToReg ? MemRData : latAlu;
          DestinationRegOut    <= latDest;
        end
      end else if (ValidIn) begin
        PCSrcOut               <= BranchIn & ZeroIn;
        BranchTargetAddressOut <= BranchTargetAddressIn;
        if (HiLoWriteIn) begin
          HiOut <= ALUResultIn[63:32];
          LoOut <= ALUResultIn[31:0];
        end
        if (memOp && !aligned) begin
          MisalignedOut <= 1'b1;
        end else if (!memOp) begin
          RegWriteOut          <= RegWriteIn;
          RegisterWriteDataOut <= ALUResultIn[31:0];
          DestinationRegOut    <= DestinationRegIn;
        end
      end
    end
  end

endmodule
